apb_arb_master: RTL and testbench

// - APB master controller that sequences the slave read-back mux (prdata/pready -> mst_prdata/mst_pready).
// - Shares one APB bus among NREQ requesters with round-robin arbitration.
// - Decodes the address into the one-hot psel that steers the mux.
// - Runs SETUP/ACCESS phases, waits on mst_pready with a timeout, returns the response to the granted requester.

---
 rtl/apb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/apb_arb_master.sv | 146 ++++++++++++++
 tb/tb_apb_arb_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB arbitrating master.
// - state_t      : bus sequencer states
// - SLV_IDX_LSB  : lowest address bit of the slave index field
// - SLV_IDX_W    : width of the slave index field
// - DEC_HI_LSB   : lowest address bit that must be zero for a decode hit
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } state_t;

    localparam int SLV_IDX_LSB = 12;
    localparam int SLV_IDX_W   = 2;
    localparam int DEC_HI_LSB  = 14;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over NREQ requesters.
// - pclk, preset : clock and synchronous active-high reset
// - req          : per-requester request
// - advance      : the current grant was taken; move the pointer past it
// - grant        : one-hot grant, first active request at or after the pointer
// - grant_idx    : binary index of the granted requester
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic [PW-1:0] ptr_q;
    logic          found;
    int            idx;

    // NOTE: every variable driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters.
// - pclk, preset          : clock and synchronous active-high reset
// - req_valid/write/addr/wdata : per-requester transfer request, held until req_ready
// - req_ready             : one-hot accept pulse (IDLE only)
// - rsp_valid/rdata/err   : one-hot completion pulse, read data, error flag
// - paddr/pwrite/pwdata   : APB request fields, held from the last accepted transfer
// - psel/penable          : one-hot slave select and access-phase strobe
// - mst_prdata/mst_pready : muxed slave read data and ready
// Slave index is addr[13:12]; any set bit above bit 13 or an index beyond NSLV
// is a decode miss answered with an error and no bus cycle.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NSLV    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     rsp_err,
    output logic [AW-1:0]            paddr,
    output logic                     pwrite,
    output logic [DW-1:0]            pwdata,
    output logic [NSLV-1:0]          psel,
    output logic                     penable,
    input  logic [DW-1:0]            mst_prdata,
    input  logic                     mst_pready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                 state_q, state_d;
    logic [NREQ-1:0]        grant;
    logic [PW-1:0]          grant_idx, gnt_q;
    logic                   advance, dec_miss, done_ok, done_err;
    logic [SLV_IDX_W-1:0]   grant_slv;
    logic [NSLV-1:0]        psel_dec;
    logic [CW-1:0]          cnt_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Decode the winning request's address before it is latched, so a miss
    // can branch straight to ERR without touching the bus.
    assign grant_slv = req_addr[grant_idx][SLV_IDX_LSB +: SLV_IDX_W];
    assign dec_miss  = (|req_addr[grant_idx][AW-1:DEC_HI_LSB]) ||
                       (int'(grant_slv) >= NSLV);
    assign psel_dec  = NSLV'(1) << paddr[SLV_IDX_LSB +: SLV_IDX_W];

    always_ff @(posedge pclk) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        psel      = '0;
        penable   = 1'b0;
        advance   = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by preset so req_ready stays low while in reset.
                if (|req_valid && !preset) begin
                    advance   = 1'b1;
                    req_ready = grant;
                    state_d   = dec_miss ? ERR : SETUP;
                end
            end
            SETUP: begin
                psel    = psel_dec;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = psel_dec;
                penable = 1'b1;
                // A ready on the last allowed cycle still completes normally.
                if (mst_pready) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            ERR: begin
                done_err = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            gnt_q     <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            cnt_q     <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (advance) begin
                gnt_q  <= grant_idx;
                paddr  <= req_addr[grant_idx];
                pwrite <= req_write[grant_idx];
                pwdata <= req_wdata[grant_idx];
                cnt_q  <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_ok) begin
                rsp_valid <= NREQ'(1) << gnt_q;
                rsp_rdata <= pwrite ? '0 : mst_prdata;
            end
            if (done_err) begin
                rsp_valid <= NREQ'(1) << gnt_q;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Randomised scoreboard bench for apb_arb_master. The reference model works on
// whole transactions: round-robin pick by index, a fixed latency per outcome
// and a phase timeline for psel/penable, all derived from the transfer rules.
module tb_apb_arb_master;

    localparam int NREQ = 2, NSLV = 4, AW = 32, DW = 32, TIMEOUT = 16;

    logic                    pclk = 1'b0;
    logic                    preset;
    logic [NREQ-1:0]         req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [DW-1:0]           rsp_rdata, pwdata, mst_prdata;
    logic [AW-1:0]           paddr;
    logic [NSLV-1:0]         psel;
    logic                    rsp_err, pwrite, penable, mst_pready;

    apb_arb_master #(.NREQ(NREQ), .NSLV(NSLV), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel),
        .penable(penable), .mst_prdata(mst_prdata), .mst_pready(mst_pready)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          req;
        bit          err;
        logic [DW-1:0] rdata;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Pending request per requester (the requester side of the stimulus).
    bit            rq_valid [NREQ];
    bit            rq_write [NREQ];
    logic [AW-1:0] rq_addr  [NREQ];
    logic [DW-1:0] rq_wdata [NREQ];
    logic [DW-1:0] rq_rdata [NREQ];
    int            rq_wait  [NREQ];

    // Transaction-level model state.
    int            rr_ptr = 0;
    int            busy_until = 0;
    bit            cur_active = 0;
    bit            cur_miss, cur_write;
    int            cur_t, cur_due, cur_wait, acc_seen;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, cur_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_miss(input logic [AW-1:0] a);
        return (a[AW-1:14] != '0) || (int'(a[13:12]) >= NSLV);
    endfunction

    task automatic drive_ports();
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r] = rq_valid[r];
            req_write[r] = rq_write[r];
            req_addr[r]  = rq_valid[r] ? rq_addr[r]  : AW'($urandom);
            req_wdata[r] = rq_valid[r] ? rq_wdata[r] : DW'($urandom);
        end
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int w, input logic [DW-1:0] rd);
        rq_valid[r] = 1'b1; rq_write[r] = wr; rq_addr[r] = a;
        rq_wdata[r] = wd;   rq_wait[r]  = w;  rq_rdata[r] = rd;
        drive_ports();
    endtask

    task automatic new_req(input int r, input bit allow_miss, input bit allow_long);
        logic [1:0]  sidx;
        logic [AW-1:0] a;
        int          w;
        sidx = 2'($urandom_range(0, 3));
        a    = {18'b0, sidx, 12'($urandom)};
        if (allow_miss && $urandom_range(0, 7) == 0)
            a[AW-1:14] = 18'($urandom_range(1, 262143));
        w = $urandom_range(0, 3);
        if (allow_long && $urandom_range(0, 9) == 0) w = $urandom_range(14, 17);
        rq_valid[r] = 1'b1; rq_write[r] = 1'($urandom); rq_addr[r] = a;
        rq_wdata[r] = DW'($urandom); rq_rdata[r] = DW'($urandom); rq_wait[r] = w;
    endtask

    task automatic accept_model(input int g);
        exp_t e;
        cur_active = 1'b1;  cur_t = cyc;
        cur_addr  = rq_addr[g];  cur_write = rq_write[g];
        cur_wdata = rq_wdata[g]; cur_rdata = rq_rdata[g];
        cur_wait  = rq_wait[g];  cur_miss  = is_miss(rq_addr[g]);
        e.req = g;
        if (cur_miss) begin
            e.err = 1'b1; e.due = cyc + 2;
        end else if (cur_wait <= TIMEOUT - 1) begin
            e.err = 1'b0; e.due = cyc + 3 + cur_wait;
        end else begin
            e.err = 1'b1; e.due = cyc + 2 + TIMEOUT;
        end
        e.rdata = (e.err || cur_write) ? '0 : cur_rdata;
        cur_due    = e.due;
        busy_until = e.due;
        sb.push_back(e);
        rr_ptr      = (g + 1) % NREQ;
        rq_valid[g] = 1'b0;
        acc_seen    = 0;
    endtask

    // One bus cycle: check and respond at the falling edge, then change the
    // requests just after the rising edge so accepted requests stay held.
    task automatic tick(input int mode);
        logic [NSLV-1:0] e_psel;
        logic            e_pen;
        logic [NREQ-1:0] exp_rdy;
        int              g, idx;
        @(negedge pclk);
        e_psel = '0;
        e_pen  = 1'b0;
        if (cur_active && !cur_miss && cyc > cur_t && cyc < cur_due) begin
            e_psel = NSLV'(1) << cur_addr[13:12];
            e_pen  = (cyc - cur_t) >= 2;
        end
        check("psel", 64'(psel), 64'(e_psel));
        check("penable", 64'(penable), 64'(e_pen));
        if (e_psel != '0) begin
            check("paddr", 64'(paddr), 64'(cur_addr));
            check("pwrite", 64'(pwrite), 64'(cur_write));
            check("pwdata", 64'(pwdata), 64'(cur_wdata));
        end
        exp_rdy = '0;
        g = -1;
        if (cyc >= busy_until) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (rr_ptr + i) % NREQ;
                if (g < 0 && rq_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0) accept_model(g);
        if (psel != '0 && penable) begin
            mst_pready = (acc_seen == cur_wait);
            mst_prdata = cur_rdata;
            acc_seen++;
        end else begin
            mst_pready = 1'b0;
            mst_prdata = DW'($urandom);
        end
        @(posedge pclk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (!rq_valid[r]) begin
                if (mode == 1 && $urandom_range(0, 2) == 0) new_req(r, 1'b1, 1'b1);
                if (mode == 2) new_req(r, 1'b0, 1'b0);
            end
        end
        if (mode == 2) for (int r = 0; r < NREQ; r++) rq_wait[r] = rq_valid[r] ? 0 : rq_wait[r];
        drive_ports();
    endtask

    task automatic wait_accept(input int r);
        for (int n = 0; n < 100 && rq_valid[r]; n++) tick(0);
        check("accept_bound", 64'(rq_valid[r]), 64'(0));
    endtask

    task automatic drain();
        int pend;
        for (int n = 0; n < 400; n++) begin
            pend = 0;
            for (int r = 0; r < NREQ; r++) pend += int'(rq_valid[r]);
            if (pend == 0 && sb.size() == 0 && cyc > busy_until) break;
            tick(0);
        end
        check("drain_bound", 64'(sb.size()), 64'(0));
    endtask

    // Response monitor: pops the scoreboard whenever a completion appears.
    exp_t me;
    always @(negedge pclk) begin
        if (!preset && cyc > 0) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    me = sb.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << me.req));
                    check("rsp_err", 64'(rsp_err), 64'(me.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
                    check("rsp_cycle", 64'(cyc), 64'(me.due));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                me = sb.pop_front();
                check("rsp_missing", 64'(rsp_valid), 64'(NREQ'(1) << me.req));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        preset     = 1'b1;
        mst_pready = 1'b0;
        mst_prdata = '0;
        for (int r = 0; r < NREQ; r++) rq_valid[r] = 1'b0;
        // Both requesters already asking during reset: req_ready must stay low.
        for (int r = 0; r < NREQ; r++) new_req(r, 1'b0, 1'b0);
        for (int r = 0; r < NREQ; r++) rq_wait[r] = 0;
        drive_ports();
        repeat (3) @(negedge pclk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        @(posedge pclk);
        #1 preset = 1'b0;

        // Continuous requests from both: alternating grants every 3 cycles.
        repeat (20) tick(2);
        drain();

        // Read, zero wait states.
        set_req(0, 1'b0, 32'h0000_1004, 32'h0, 0, 32'hCAFE_0001);
        wait_accept(0); drain();
        // Write with three wait states.
        set_req(1, 1'b1, 32'h0000_3000, 32'h1234_5678, 3, 32'h0);
        wait_accept(1); drain();
        // Ready on the very last allowed ACCESS cycle, then never ready.
        set_req(0, 1'b0, 32'h0000_2010, 32'h0, TIMEOUT - 1, 32'h5A5A_A5A5);
        wait_accept(0); drain();
        set_req(1, 1'b0, 32'h0000_0020, 32'h0, TIMEOUT, 32'hDEAD_BEEF);
        wait_accept(1); drain();
        // Decode miss.
        set_req(0, 1'b1, 32'h0001_4000, 32'hFFFF_0000, 0, 32'h0);
        wait_accept(0); drain();

        repeat (1500) tick(1);
        drain();

        // Abort in ACCESS: grant req0 first so the pointer sits at req1.
        set_req(0, 1'b0, 32'h0000_2000, 32'h0, 0, 32'h1111_2222);
        wait_accept(0); drain();
        set_req(1, 1'b0, 32'h0000_1000, 32'h0, 10, 32'h3333_4444);
        wait_accept(1);
        tick(0); tick(0);
        preset = 1'b1;
        sb.delete();
        cur_active = 1'b0; busy_until = 0; rr_ptr = 0;
        for (int r = 0; r < NREQ; r++) rq_valid[r] = 1'b0;
        drive_ports();
        @(negedge pclk);
        @(negedge pclk);
        check("abort_psel", 64'(psel), 64'(0));
        check("abort_penable", 64'(penable), 64'(0));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge pclk);
        #1 preset = 1'b0;
        set_req(0, 1'b0, 32'h0000_3008, 32'h0, 1, 32'h7777_0000);
        set_req(1, 1'b1, 32'h0000_0008, 32'h9999_0000, 0, 32'h0);
        tick(0);
        check("abort_next_grant", 64'(rq_valid[0]), 64'(0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
